// File: rtl/tlc_intersection.sv
// tlc_intersection: two-road intersection controller.
// The main road rests on green; the side road is served only after a latched
// vehicle-sensor or pedestrian request. All-red clearance separates the greens.
// The lamps are registered Moore outputs, decoded from the next-state value.
// Optional feature: define TLC_FLASH_EN to add the flash_req input and a
// FLASH state in which main yellow and side red blink together.

module tlc_intersection #(
   parameter int CNT_W      = 8,
   parameter int MAIN_MIN_G = 20,
   parameter int MAIN_Y_T   = 4,
   parameter int ALLRED_T   = 2,
   parameter int SIDE_G_T   = 12,
   parameter int SIDE_Y_T   = 4,
   parameter int FLASH_T    = 8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       side_sensor,
   input  logic       ped_btn,
`ifdef TLC_FLASH_EN
   input  logic       flash_req,
`endif
   output logic       main_r,
   output logic       main_y,
   output logic       main_g,
   output logic       side_r,
   output logic       side_y,
   output logic       side_g,
   output logic       walk,
   output logic       req_pending,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      MAIN_G = 3'd0,
      MAIN_Y = 3'd1,
      CLR_MS = 3'd2,
      SIDE_G = 3'd3,
      SIDE_Y = 3'd4,
      CLR_SM = 3'd5
`ifdef TLC_FLASH_EN
      , FLASH = 3'd6
`endif
   } state_t;

   typedef struct packed {
      logic main_r;
      logic main_y;
      logic main_g;
      logic side_r;
      logic side_y;
      logic side_g;
      logic walk;
   } lamps_t;

   // Timer values on the last cycle of each timed state.
   localparam logic [CNT_W-1:0] TMAX         = '1;
   localparam logic [CNT_W-1:0] MAIN_MIN_END = CNT_W'(MAIN_MIN_G - 1);
   localparam logic [CNT_W-1:0] MAIN_Y_END   = CNT_W'(MAIN_Y_T - 1);
   localparam logic [CNT_W-1:0] ALLRED_END   = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] SIDE_G_END   = CNT_W'(SIDE_G_T - 1);
   localparam logic [CNT_W-1:0] SIDE_Y_END   = CNT_W'(SIDE_Y_T - 1);
`ifdef TLC_FLASH_EN
   localparam logic [CNT_W-1:0] FLASH_END    = CNT_W'(FLASH_T - 1);
`endif

   // Both roads red, nothing else lit: the reset and clearance picture.
   localparam lamps_t LAMPS_ALLRED = '{main_r: 1'b1, side_r: 1'b1, default: 1'b0};

   state_t           state, state_nxt;
   logic [CNT_W-1:0] timer, timer_nxt;
   logic             req_lat, ped_lat, walk_serve, walk_serve_nxt;
   logic             enter_side, req_in;
   lamps_t           lamps, lamps_nxt;
`ifdef TLC_FLASH_EN
   logic             flash_on, flash_on_nxt;
`endif

   assign req_in = side_sensor | ped_btn;

   // Next state, phase timer and walk-serve flag.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_nxt = state;
      case (state)
         MAIN_G: if (req_lat && timer >= MAIN_MIN_END) state_nxt = MAIN_Y;
         MAIN_Y: if (timer == MAIN_Y_END) state_nxt = CLR_MS;
         CLR_MS: if (timer == ALLRED_END) begin
`ifdef TLC_FLASH_EN
            state_nxt = flash_req ? FLASH : SIDE_G;
`else
            state_nxt = SIDE_G;
`endif
         end
         SIDE_G: if (timer == SIDE_G_END) state_nxt = SIDE_Y;
         SIDE_Y: if (timer == SIDE_Y_END) state_nxt = CLR_SM;
         CLR_SM: if (timer == ALLRED_END) begin
`ifdef TLC_FLASH_EN
            state_nxt = flash_req ? FLASH : MAIN_G;
`else
            state_nxt = MAIN_G;
`endif
         end
`ifdef TLC_FLASH_EN
         FLASH:  if (timer == FLASH_END && !flash_req) state_nxt = CLR_SM;
`endif
         default: state_nxt = CLR_SM;
      endcase

      // Restart on every state change; main green parks at full scale instead of wrapping.
      if (state_nxt != state)                      timer_nxt = '0;
      else if (state == MAIN_G && timer == TMAX)   timer_nxt = timer;
`ifdef TLC_FLASH_EN
      else if (state == FLASH && timer == FLASH_END) timer_nxt = '0;
`endif
      else                                         timer_nxt = timer + CNT_W'(1);

      enter_side     = (state == CLR_MS) && (state_nxt == SIDE_G);
      walk_serve_nxt = enter_side ? ped_lat : walk_serve;

`ifdef TLC_FLASH_EN
      flash_on_nxt = flash_on;
      if (state_nxt == FLASH) begin
         if (state != FLASH)          flash_on_nxt = 1'b1;
         else if (timer == FLASH_END) flash_on_nxt = ~flash_on;
      end
`endif
   end

   // Lamp decode of the upcoming state, so the registered lamps track the state register.
   always_comb begin
      lamps_nxt = LAMPS_ALLRED;
      case (state_nxt)
         MAIN_G: begin lamps_nxt.main_r = 1'b0; lamps_nxt.main_g = 1'b1; end
         MAIN_Y: begin lamps_nxt.main_r = 1'b0; lamps_nxt.main_y = 1'b1; end
         SIDE_G: begin
            lamps_nxt.side_r = 1'b0;
            lamps_nxt.side_g = 1'b1;
            lamps_nxt.walk   = walk_serve_nxt;
         end
         SIDE_Y: begin lamps_nxt.side_r = 1'b0; lamps_nxt.side_y = 1'b1; end
`ifdef TLC_FLASH_EN
         FLASH: begin
            lamps_nxt.main_r = 1'b0;
            lamps_nxt.main_y = flash_on_nxt;
            lamps_nxt.side_r = flash_on_nxt;
         end
`endif
         default: ;
      endcase
   end

   // FSM state, timer, request latches and registered lamps.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= CLR_SM;
         timer      <= '0;
         req_lat    <= 1'b0;
         ped_lat    <= 1'b0;
         walk_serve <= 1'b0;
         lamps      <= LAMPS_ALLRED;
`ifdef TLC_FLASH_EN
         flash_on   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         state      <= state_nxt;
         timer      <= timer_nxt;
         // A request arriving on the SIDE_G entry cycle wins over the clear.
         req_lat    <= req_in | (req_lat & ~enter_side);
         ped_lat    <= enter_side ? ped_btn : (ped_lat | ped_btn);
         walk_serve <= walk_serve_nxt;
         lamps      <= lamps_nxt;
`ifdef TLC_FLASH_EN
         flash_on   <= flash_on_nxt;
`endif
      end
   end

   assign main_r      = lamps.main_r;
   assign main_y      = lamps.main_y;
   assign main_g      = lamps.main_g;
   assign side_r      = lamps.side_r;
   assign side_y      = lamps.side_y;
   assign side_g      = lamps.side_g;
   assign walk        = lamps.walk;
   assign req_pending = req_lat;
   assign phase       = state;

endmodule

// File: doc/tlc_intersection.md
Name: tlc_intersection

Overview:
- Parametrised two-road intersection controller; successor to the single-signal fixed-timing traffic light controller.
- Drives main-road and side-road red/yellow/green lamps plus a pedestrian walk lamp.
- Main road rests on green. The block serves the side road only when a latched vehicle-sensor or pedestrian request exists.
- Phase durations are set by parameters. All-red clearance intervals separate conflicting greens.

Parameters:
- CNT_W, 8, phase timer width in bits.
- MAIN_MIN_G, 20, minimum main-green cycles.
- MAIN_Y_T, 4, main-yellow cycles.
- ALLRED_T, 2, all-red clearance cycles.
- SIDE_G_T, 12, side-green cycles.
- SIDE_Y_T, 4, side-yellow cycles.
- FLASH_T, 8, flash half-period cycles (used only with the optional feature).

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- side_sensor  in  1  side-road vehicle present, level.
- ped_btn  in  1  pedestrian request, level or pulse.
- main_r, main_y, main_g  out  1 each  main-road lamps.
- side_r, side_y, side_g  out  1 each  side-road lamps.
- walk  out  1  pedestrian walk lamp.
- req_pending  out  1  latched side-service request.
- phase  out  3  current state encoding, for debug.

Behaviour:
- States and encoding: MAIN_G=0, MAIN_Y=1, CLR_MS=2 (all red, main to side), SIDE_G=3, SIDE_Y=4, CLR_SM=5 (all red, side to main), FLASH=6.
- Timer: reset to 0 on every state change; otherwise increments each cycle. A timed state of length T lasts exactly T cycles and exits when timer==T-1.
- In MAIN_G the timer saturates at 2^CNT_W-1 and does not wrap.
- Parameter legality: every timing parameter must be >=1 and <=2^CNT_W-1. Illegal values are not checked.
- Reset (asynchronous assert, synchronous release):
  - state=CLR_SM, timer=0, req latch=0, ped latch=0.
  - Outputs: main_r=side_r=1; all yellows, greens, walk=0; phase=5.
  - After release, CLR_SM runs ALLRED_T cycles, then MAIN_G.
  - Reset asserted mid-phase forces all-red immediately, with no yellow.
- Transitions:
  - MAIN_G -> MAIN_Y when timer>=MAIN_MIN_G-1 and req latch=1. With no request, MAIN_G holds indefinitely.
  - MAIN_Y -> CLR_MS after MAIN_Y_T cycles.
  - CLR_MS -> SIDE_G after ALLRED_T cycles.
  - SIDE_G -> SIDE_Y after SIDE_G_T cycles.
  - SIDE_Y -> CLR_SM after SIDE_Y_T cycles.
  - CLR_SM -> MAIN_G after ALLRED_T cycles.
- Request latch:
  - Sets on any cycle with side_sensor|ped_btn.
  - Clears on the cycle the FSM enters SIDE_G, unless a request input is high that same cycle; set wins.
  - Requests arriving during SIDE_G, SIDE_Y or CLR_SM are held and served in the next cycle of the sequence.
  - req_pending equals the latch.
- Ped latch:
  - Sets on ped_btn in any state.
  - On entry to SIDE_G its value transfers to a walk-serve flag, and the latch clears.
  - walk=1 throughout SIDE_G only when the walk-serve flag is set; walk=0 in every other state.
- Lamp decode: Moore outputs, decoded from the state register only, with no combinational path from inputs.
  - main_g only in MAIN_G; main_y only in MAIN_Y; main_r in all other states.
  - side_g only in SIDE_G; side_y only in SIDE_Y; side_r in all other states.
- Safety invariants: exactly one lamp per road is lit; main_g and side_g are never both 1; every green is preceded by an all-red state.

Optional Feature:
- Macro: TLC_FLASH_EN.
- Defined:
  - Adds input flash_req (1 bit).
  - When flash_req=1 at the final cycle of CLR_MS or CLR_SM, the FSM enters FLASH instead of the next green.
  - In FLASH: main_y and side_r toggle together every FLASH_T cycles, starting lit; all other lamps and walk are 0.
  - When flash_req=0 at a toggle boundary, the FSM goes to CLR_SM. Request latches are held throughout.
- Undefined: no flash_req port, no FLASH state, state 6 unreachable.

Test Plan (MAIN_MIN_G=8, MAIN_Y_T=3, ALLRED_T=2, SIDE_G_T=5, SIDE_Y_T=3, CNT_W=4):
- reset_n low for 3 cycles, then high -> all reds lit, phase=5 for 2 cycles; main_g=1 at the 3rd cycle after release.
- No requests for 100 cycles -> main_g stays 1; timer saturates at 15 without wrapping; req_pending=0.
- side_sensor pulse at main-green cycle 2 -> req_pending=1; sequence runs MAIN_G for 8 cycles total, then MAIN_Y 3, CLR_MS 2, SIDE_G 5, SIDE_Y 3, CLR_SM 2; walk stays 0.
- ped_btn pulse during MAIN_G -> walk=1 for exactly the 5 SIDE_G cycles; second ped_btn during SIDE_G -> walk=1 again in the following side cycle.
- reset_n pulsed low during SIDE_G cycle 3 -> same cycle main_r=side_r=1, side_g=0, and req_pending=0.
- With TLC_FLASH_EN: flash_req=1 during CLR_MS -> FLASH; main_y/side_r toggle every 8 cycles; after flash_req drops -> CLR_SM for 2 cycles, then MAIN_G.
